// File: rtl/pwm_duty_meter.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// pwm_duty_meter: measures PWM period/high time and computes the duty percentage
// with a restoring divider. Optional macro PWM_DUTY_BCD_EN adds a BCD duty output.
// Revision: 1.0
//------------------------------------------------------------------------------
module pwm_duty_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK_FPGA_BOARD,
  input  logic             reinicio,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic [6:0]       duty_pct_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [1:0]       stuck_o,
  output logic             overrun_o
`ifdef PWM_DUTY_BCD_EN
  ,
  output logic [11:0]      duty_bcd_o
`endif
);

  localparam int               NUM_W   = CNT_W + 7;
  localparam int               IT_W    = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    S_WAIT_RISE = 1'b0,
    S_COUNT     = 1'b1
  } state_t;

  state_t r_state, w_state_nx;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pwm_prev;
  logic                   w_pwm_s, w_rise;
  logic [CNT_W-1:0]       r_period_cnt, r_high_cnt;
  logic                   w_snap, w_timeout, w_div_free, w_load;

  logic             r_busy, r_done;
  logic [IT_W-1:0]  r_iter;
  logic [NUM_W-1:0] r_num, w_num_load;
  logic [CNT_W-1:0] r_rem, r_div, r_h_snap;
  logic [7:0]       r_quo, w_quo_nx;
  logic             r_qovf, w_qovf_nx;
  logic [CNT_W:0]   w_rem_sh, w_diff;
  logic             w_ge;
  logic [6:0]       w_duty_fin;

  assign w_pwm_s = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_pwm_s & ~r_pwm_prev;

  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) begin
      r_sync     <= '0;
      r_pwm_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_pwm_prev <= w_pwm_s;
    end
  end

  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) r_state <= S_WAIT_RISE;
    else           r_state <= w_state_nx;
  end

  // enable has priority; a rise beats a coincident timeout
  always_comb begin
    w_state_nx = r_state;
    w_snap     = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_WAIT_RISE: if (enable && w_rise) w_state_nx = S_COUNT;
      S_COUNT: begin
        if (!enable) begin
          w_state_nx = S_WAIT_RISE;
        end else if (w_rise) begin
          w_snap = 1'b1;
        end else if (r_period_cnt == CNT_MAX) begin
          w_timeout  = 1'b1;
          w_state_nx = S_WAIT_RISE;
        end
      end
      default: w_state_nx = S_WAIT_RISE;
    endcase
  end

  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
    end else if (w_state_nx == S_COUNT) begin
      if (r_state == S_WAIT_RISE || w_snap) begin
        r_period_cnt <= CNT_W'(1);
        r_high_cnt   <= CNT_W'(1);
      end else begin
        r_period_cnt <= r_period_cnt + CNT_W'(1);
        r_high_cnt   <= r_high_cnt + CNT_W'(w_pwm_s);
      end
    end else begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
    end
  end

  // The completion cycle still counts as occupied, so a snapshot there is dropped
  assign w_div_free = ~r_busy & ~r_done;
  assign w_load     = w_snap & w_div_free;
  assign w_num_load = NUM_W'(r_high_cnt) * NUM_W'(100);

  assign w_rem_sh   = {r_rem, r_num[NUM_W-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_ge       = ~w_diff[CNT_W];
  assign w_quo_nx   = {r_quo[6:0], w_ge};
  assign w_qovf_nx  = r_qovf | r_quo[7];
  assign w_duty_fin = (w_qovf_nx || (w_quo_nx > 8'd100)) ? 7'd100 : w_quo_nx[6:0];

  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) begin
      r_busy   <= 1'b0;
      r_iter   <= '0;
      r_num    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_qovf   <= 1'b0;
      r_div    <= '0;
      r_h_snap <= '0;
    end else if (w_load) begin
      r_busy   <= 1'b1;
      r_iter   <= IT_W'(NUM_W);
      r_num    <= w_num_load;
      r_rem    <= '0;
      r_quo    <= '0;
      r_qovf   <= 1'b0;
      r_div    <= r_period_cnt;
      r_h_snap <= r_high_cnt;
    end else if (r_busy) begin
      r_num  <= {r_num[NUM_W-2:0], 1'b0};
      r_rem  <= w_ge ? w_diff[CNT_W-1:0] : w_rem_sh[CNT_W-1:0];
      r_quo  <= w_quo_nx;
      r_qovf <= w_qovf_nx;
      r_iter <= r_iter - IT_W'(1);
      if (r_iter == IT_W'(1)) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) begin
      r_done     <= 1'b0;
      period_o   <= '0;
      high_o     <= '0;
      duty_pct_o <= '0;
      stuck_o    <= 2'b00;
      overrun_o  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy && r_iter == IT_W'(1)) begin
        r_done     <= 1'b1;
        period_o   <= r_div;
        high_o     <= r_h_snap;
        duty_pct_o <= w_duty_fin;
        stuck_o    <= 2'b00;
      end else if (w_timeout) begin
        r_done     <= 1'b1;
        period_o   <= '0;
        high_o     <= w_pwm_s ? CNT_MAX : '0;
        duty_pct_o <= w_pwm_s ? 7'd100 : 7'd0;
        stuck_o    <= w_pwm_s ? 2'b10 : 2'b01;
      end
      if (w_snap && !w_div_free) overrun_o <= 1'b1;
    end
  end

  assign busy_o = r_busy;

`ifdef PWM_DUTY_BCD_EN
  logic [6:0] w_mod100;
  logic [3:0] w_tens, w_units;
  logic       w_hund;
  logic       r_valid_d;

  always_comb begin
    w_hund   = (duty_pct_o == 7'd100);
    w_mod100 = w_hund ? 7'd0 : duty_pct_o;
    w_tens   = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (w_mod100 >= 7'(10 * k)) w_tens = 4'(k);
    end
    w_units  = 4'(w_mod100 - 7'(w_tens) * 7'd10);
  end

  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) begin
      r_valid_d  <= 1'b0;
      duty_bcd_o <= '0;
    end else begin
      r_valid_d  <= r_done;
      duty_bcd_o <= {3'b000, w_hund, w_tens, w_units};
    end
  end

  assign valid_o = r_valid_d;
`else
  assign valid_o = r_done;
`endif

endmodule
`default_nettype wire

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Receive-side counterpart of the DPWM generator.
- Samples a PWM waveform (BUCK_Gate or Full_Bridge, looped back or from an external pin) and measures its period and high time in CLK_FPGA_BOARD cycles.
- Computes duty cycle as an integer percentage with a sequential divider, so the 7-segment path can show the measured duty rather than the commanded duty.
- Detects a stuck-high or stuck-low input.

Parameters:
CNT_W, 16, width of the period and high-time counters
SYNC_STAGES, 2, flip-flop stages in the pwm_in synchronizer (minimum 2)

Ports:
CLK_FPGA_BOARD  input  1  system clock
reinicio  input  1  asynchronous, active-low reset
pwm_in  input  1  PWM waveform under measurement, asynchronous to the clock
enable  input  1  measurement enable; low forces the WAIT_RISE state
period_o  output  CNT_W  last measured period in cycles; 0 = stuck/invalid
high_o  output  CNT_W  last measured high time in cycles
duty_pct_o  output  7  duty in percent, 0..100, truncated
valid_o  output  1  one-cycle pulse when all result outputs update
busy_o  output  1  divider in progress
stuck_o  output  2  01 = stuck low, 10 = stuck high, 00 = toggling
overrun_o  output  1  sticky; a snapshot was dropped because the divider was busy

Behaviour:
- Reset (reinicio=0, asynchronous): all outputs 0, synchronizer cleared, FSM in WAIT_RISE. Reset applied mid-division abandons the division and produces no valid_o.
- Synchronizer: pwm_s is pwm_in after SYNC_STAGES flops. A rise is pwm_s=1 with the previous pwm_s=0. A cycle is counted high when pwm_s=1.
- FSM states:
  - WAIT_RISE: counters held at 0. On a rise, set period_cnt=1 and high_cnt=1, then go to COUNT.
  - COUNT: each cycle, period_cnt increments and high_cnt increments when pwm_s=1.
  - On a rise while in COUNT (snapshot cycle T): latch period_cnt into P and high_cnt into H, then restart the counters at 1/1.
  - If the divider is idle at T, it loads at T+1. If it is busy at T, the snapshot is dropped and overrun_o is set to 1. Only reset clears overrun_o.
  - enable=0 in any state: return to WAIT_RISE next cycle. A division already running still completes.
- Timeout: if period_cnt reaches 2^CNT_W-1 in COUNT without a rise:
  - pwm_s=1: stuck_o=10, duty_pct_o=100, high_o=all-ones.
  - pwm_s=0: stuck_o=01, duty_pct_o=0, high_o=0.
  - In both cases period_o=0, valid_o pulses the next cycle, and the FSM returns to WAIT_RISE.
  - Any normal valid result clears stuck_o to 00.
- Divider: unsigned restoring shift-subtract computing (H*100)/P.
  - Numerator width is CNT_W+7. It takes one iteration per cycle for CNT_W+7 cycles.
  - valid_o is asserted at cycle T+CNT_W+8. period_o, high_o and duty_pct_o update in that same cycle.
  - busy_o is high from T+1 through T+CNT_W+7.
  - The quotient is clamped to 100. H>P cannot occur by construction; the clamp is a safety net.
  - The minimum period measured without overrun is CNT_W+9 cycles.
- A timeout result and a divider completion never occur in the same cycle. Timeout requires no rise for 2^CNT_W-1 cycles, which exceeds the divider latency.

Optional Feature:
PWM_DUTY_BCD_EN
- Defined:
  - Adds output duty_bcd_o[11:0]: hundreds in [11:8], tens in [7:4], units in [3:0].
  - Converted from duty_pct_o through one register stage.
  - valid_o is delayed by one cycle (T+CNT_W+9) so it aligns with duty_bcd_o. All other outputs keep their timing.
  - Reset value 0.
- Not defined: the port and the conversion logic are absent, and valid_o stays at T+CNT_W+8.

Test Plan:
- Reset, enable=1, pwm_in period 100 cycles, high 25, three periods → second valid_o gives period_o=100, high_o=25, duty_pct_o=25, stuck_o=00, valid_o exactly at snapshot+24.
- Period 200, high 199 → duty_pct_o=99. Period 3 (high 1): second snapshot dropped, overrun_o=1 and stays 1.
- Toggle pwm_in, then hold it at 1 for 65535+ cycles → valid_o pulse with stuck_o=10, duty_pct_o=100, period_o=0. Resume toggling at period 100 → stuck_o returns to 00.
- Hold pwm_in=0 after one rise → stuck_o=01, duty_pct_o=0.
- Pull reinicio low 5 cycles into a division → outputs 0 immediately, no valid_o. After release, normal measurement resumes from WAIT_RISE.
- With PWM_DUTY_BCD_EN defined, period 100, high 37 → duty_bcd_o=12'h037 with valid_o at snapshot+25. Drop enable mid-COUNT → no further snapshots until re-enabled.
